decoder_scan_nx2n: RTL and testbench
====================================

// Module: decoder_scan_nx2n
// PURPOSE
//  Parametrised N-to-2^N one-hot decoder with enable and registered outputs.
//  Two modes: DIRECT (decode input w) and SCAN (auto-step through outputs,
//  holding each for DWELL cycles). Drives row/digit/chip selects in lab
//  designs, replacing fixed 2x4 decoders.
// PARAMETERS
//  N      2  select width; output width is 2**N (N >= 1)
//  DWELL  4  cycles each output stays active in SCAN mode (DWELL >= 1)
// PORTS
//  clk      in   1     rising-edge clock
//  reset_n  in   1     asynchronous, active-low reset
//  en       in   1     enable; 0 forces y to zero and pauses scan
//  mode     in   1     0 = DIRECT, 1 = SCAN
//  w        in   N     select (DIRECT) / start index (SCAN with load)
//  load     in   1     SCAN only: idx <= w and dwell counter cleared
//  y        out  2**N  one-hot output, declared [0:2**N-1]; y[k] = index k
//  idx      out  N     currently decoded index
//  valid    out  1     1 when y holds a live one-hot value
//  wrap     out  1     one-cycle pulse when SCAN steps from 2**N-1 to 0
// BEHAVIOUR
//  - Reset (async assert, sync release): y=0, idx=0, valid=0, wrap=0,
//    dwell=0, state=IDLE. A mid-operation reset clears all state at once.
//  - State is a registered 2-bit value: IDLE, DIRECT, SCAN. Next state is
//    computed each cycle:
//    en=0 -> IDLE; en=1 & mode=0 -> DIRECT; en=1 & mode=1 -> SCAN.
//  - IDLE: y=0, valid=0, wrap=0. idx and dwell hold their values.
//  - DIRECT: idx<=w and y<=onehot(w) on each edge. Latency is 1 cycle from
//    w to y. dwell<=0.
//  - SCAN: y<=onehot(idx).
//    - With load=1: idx<=w, dwell<=0. This has priority over stepping.
//    - Otherwise, when dwell==DWELL-1: dwell<=0 and idx<=idx+1, wrapping
//      modulo 2**N. wrap=1 for the cycle in which idx becomes 0.
//    - Otherwise: dwell<=dwell+1.
//  - Entering SCAN from DIRECT continues from the last decoded idx, with
//    dwell restarted at 0. Entering SCAN from IDLE resumes the paused idx and
//    dwell.
//  - The dwell counter is $clog2(DWELL) bits wide, with a minimum of 1 bit.
//    DWELL=1 steps every cycle.
//  - load is ignored in DIRECT and IDLE.
//  - y is always all-zero or exactly one-hot. valid==|y.
//  - Simultaneous en fall and wrap: IDLE wins, so wrap=0.
// STRUCTURE
//  - Package dec_pkg holds the state encodings ST_IDLE=2'd0, ST_DIRECT=2'd1,
//    ST_SCAN=2'd2 and the MODE_DIRECT/MODE_SCAN constants.
//  - One sub-module: decoder_nx2n, a purely combinational parametrised
//    one-hot decoder (w -> [0:2**N-1]). It is used for both the DIRECT and
//    SCAN paths and is registered in the top module.
// TESTING (N=2, DWELL=4 unless noted)
//  1. Reset: drive reset_n=0 mid-scan -> y=4'b0000, idx=0, valid=0
//     immediately, without waiting for a clock.
//  2. DIRECT: en=1, mode=0, w=00,01,10,11 on successive cycles
//     -> one cycle later y=1000,0100,0010,0001 (y[0] leftmost); valid=1.
//  3. Disable: en=0 with any w -> y=0000 and valid=0 next cycle.
//     Re-enable with w=10 -> y=0010.
//  4. SCAN: en=1, mode=1 from idx=0 -> y=1000 for 4 cycles, then 0100, 0010,
//     0001, then 1000 again. wrap pulses for exactly 1 cycle at 0001->1000.
//  5. Load and pause: in SCAN, load=1 with w=11 -> idx=3 next cycle and
//     dwell restarts. en=0 for 3 cycles, then en=1 -> y resumes 0001 with
//     the remaining dwell.
//  6. Param sweep: N=3, DWELL=1 -> SCAN steps every cycle through 8 outputs
//     and wrap pulses every 8 cycles. Self-check that y is one-hot or zero
//     on every cycle.

Source files
------------

// File: rtl/dec_pkg.sv
// Shared state and mode encodings for the scanning one-hot decoder.
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_nx2n.sv
// Purely combinational N-to-2**N one-hot decoder; y[k] is set when sel == k.
module decoder_nx2n #(
  parameter int N = 2
) (
  input  logic [N-1:0]    sel,
  output logic [0:2**N-1] y
);

  for (genvar k = 0; k < 2**N; k++) begin : g_out
    assign y[k] = (sel == N'(k));
  end

endmodule

// File: rtl/decoder_scan_nx2n.sv
// One-hot decoder with registered outputs: DIRECT decodes w, SCAN steps the
// active output every DWELL cycles; en=0 blanks the output and pauses the scan.
module decoder_scan_nx2n
  import dec_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              mode,
  input  logic [N-1:0]      w,
  input  logic              load,
  output logic [0:2**N-1]   y,
  output logic [N-1:0]      idx,
  output logic              valid,
  output logic              wrap
);

  localparam int OUTS = 2**N;
  localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [N-1:0]  IDX_LAST   = {N{1'b1}};

  state_t          state, state_nxt;
  logic [DW-1:0]   dwell, dwell_nxt, dwell_cur;
  logic [N-1:0]    idx_nxt, dec_sel;
  logic            wrap_nxt;
  logic [0:OUTS-1] dec_y, y_nxt;

  always_comb begin
    state_nxt = ST_IDLE;
    if (en) state_nxt = (mode == MODE_SCAN) ? ST_SCAN : ST_DIRECT;
  end

  // SCAN shows the index held going into the edge, so y trails idx by one cycle.
  assign dec_sel = (state_nxt == ST_DIRECT) ? w : idx;

  decoder_nx2n #(.N(N)) u_dec (
    .sel (dec_sel),
    .y   (dec_y)
  );

  // A scan entered straight from DIRECT always starts a fresh dwell period.
  assign dwell_cur = (state == ST_DIRECT) ? '0 : dwell;

  always_comb begin
    idx_nxt   = idx;
    dwell_nxt = dwell;
    wrap_nxt  = 1'b0;
    y_nxt     = '0;
    case (state_nxt)
      ST_DIRECT: begin
        idx_nxt   = w;
        dwell_nxt = '0;
        y_nxt     = dec_y;
      end
      ST_SCAN: begin
        y_nxt = dec_y;
        if (load) begin
          idx_nxt   = w;
          dwell_nxt = '0;
        end else if (dwell_cur == DWELL_LAST) begin
          dwell_nxt = '0;
          idx_nxt   = idx + 1'b1;
          wrap_nxt  = (idx == IDX_LAST);
        end else begin
          dwell_nxt = dwell_cur + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      dwell <= '0;
      y     <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      dwell <= dwell_nxt;
      y     <= y_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign valid = |y;

endmodule

// File: tb/tb_decoder_scan_nx2n.sv
// Bench: N=2/DWELL=4 and N=3/DWELL=1 instances share stimulus and are checked
// every cycle against an integer model, plus directed literal expectations.
module tb_decoder_scan_nx2n;

  logic       clk, reset_n, en, mode, load;
  logic [2:0] w3;
  logic [0:3] y2;
  logic [0:7] y3;
  logic [1:0] idx2;
  logic [2:0] idx3;
  logic       valid2, valid3, wrap2, wrap3;

  int checks = 0;
  int errors = 0;

  decoder_scan_nx2n #(.N(2), .DWELL(4)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .w(w3[1:0]),
    .load(load), .y(y2), .idx(idx2), .valid(valid2), .wrap(wrap2));

  decoder_scan_nx2n #(.N(3), .DWELL(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .w(w3),
    .load(load), .y(y3), .idx(idx3), .valid(valid3), .wrap(wrap3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: idx/dwell as integers, expected output as an index (-1 = none).
  int m_idx[2], m_dwell[2], m_y[2];
  bit m_wrap[2];

  always @(posedge clk or negedge reset_n) begin
    int sz, dw, wv, ni, nd, ny;
    bit nw;
    for (int k = 0; k < 2; k++) begin
      sz = (k == 0) ? 4 : 8;
      dw = (k == 0) ? 4 : 1;
      wv = int'(w3) % sz;
      ni = m_idx[k]; nd = m_dwell[k]; ny = -1; nw = 1'b0;
      if (!reset_n) begin
        ni = 0; nd = 0;
      end else if (en && !mode) begin
        ni = wv; ny = wv; nd = 0;
      end else if (en) begin
        ny = m_idx[k];
        if (load) begin
          ni = wv; nd = 0;
        end else if (m_dwell[k] == dw - 1) begin
          nd = 0; ni = (m_idx[k] + 1) % sz; nw = (ni == 0);
        end else begin
          nd = m_dwell[k] + 1;
        end
      end
      m_idx[k]   <= ni;
      m_dwell[k] <= nd;
      m_y[k]     <= ny;
      m_wrap[k]  <= nw;
    end
  end

  task automatic cmp(input int k, input logic [7:0] g, input int gi, input logic v, input logic wr);
    logic [7:0] e;
    e = (m_y[k] < 0) ? 8'h00 : 8'(1 << m_y[k]);
    chk($sformatf("model_y%0d", k), 32'(g), 32'(e));
    chk($sformatf("model_idx%0d", k), gi, m_idx[k]);
    chk($sformatf("model_valid%0d", k), 32'(v), 32'(e != 0));
    chk($sformatf("model_wrap%0d", k), 32'(wr), 32'(m_wrap[k]));
    chk($sformatf("onehot%0d", k), 32'($countones(g) <= 1), 32'd1);
  endtask

  logic [7:0] g2, g3;
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      g2 = '0; g3 = '0;
      for (int i = 0; i < 4; i++) g2[i] = y2[i];
      for (int i = 0; i < 8; i++) g3[i] = y3[i];
      cmp(0, g2, int'(idx2), valid2, wrap2);
      cmp(1, g3, int'(idx3), valid3, wrap3);
    end
  end

  logic [0:3] tab4 [4];
  int nwrap;

  initial begin
    tab4[0] = 4'b1000; tab4[1] = 4'b0100; tab4[2] = 4'b0010; tab4[3] = 4'b0001;
    reset_n = 1'b0; en = 1'b0; mode = 1'b0; load = 1'b0; w3 = '0;
    repeat (2) @(negedge clk);
    chk("reset_y", 32'(y2), 0);
    chk("reset_idx", 32'(idx2), 0);
    chk("reset_valid", 32'(valid2), 0);
    reset_n = 1'b1;

    // DIRECT: one-cycle latency from w to y
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w3 = 3'(i);
      @(negedge clk);
      chk("direct_y", 32'(y2), 32'(tab4[i]));
      chk("direct_valid", 32'(valid2), 1);
    end

    en = 1'b0; w3 = 3'd1;
    @(negedge clk);
    chk("disable_y", 32'(y2), 0);
    chk("disable_valid", 32'(valid2), 0);
    en = 1'b1; w3 = 3'd2;
    @(negedge clk);
    chk("reenable_y", 32'(y2), 32'(4'b0010));

    // SCAN from idx 0
    w3 = 3'd0;
    @(negedge clk);
    mode = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      chk("scan_y", 32'(y2), 32'(tab4[((c - 1) / 4) % 4]));
      chk("scan_wrap", 32'(wrap2), 32'(c == 16));
    end

    // load, then pause mid-dwell and resume
    load = 1'b1; w3 = 3'd3;
    @(negedge clk);
    chk("load_idx", 32'(idx2), 3);
    load = 1'b0;
    @(negedge clk);
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("pause_y", 32'(y2), 0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("resume_y", 32'(y2), 32'(4'b0001));
    @(negedge clk);
    chk("resume_idx_hold", 32'(idx2), 3);
    @(negedge clk);
    chk("resume_idx_step", 32'(idx2), 0);
    chk("resume_y_last", 32'(y2), 32'(4'b0001));

    // N=3, DWELL=1: steps every cycle, wraps every 8
    mode = 1'b0; w3 = 3'd0;
    @(negedge clk);
    mode = 1'b1;
    nwrap = 0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 1) chk("n3_first_y", 32'(y3), 32'(8'b1000_0000));
      if (wrap3) nwrap++;
    end
    chk("n3_wraps", nwrap, 2);

    // asynchronous reset mid-scan, away from any clock edge
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_y", 32'(y2), 0);
    chk("async_rst_idx", 32'(idx2), 0);
    chk("async_rst_valid", 32'(valid2), 0);
    chk("async_rst_y3", 32'(y3), 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 7) == 0);
      w3   = 3'($urandom);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
